// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-flop synchroniser, press/release qualification FSM, toggle and strobes.
// Optional long-press strobe is enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_multi #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned CNT_W          = 18,
  parameter int unsigned PRESS_CYCLES   = 200000,
  parameter int unsigned RELEASE_CYCLES = 200000,
  parameter int unsigned LONG_W         = 26,
  parameter int unsigned LONG_CYCLES    = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button_i,
  input  logic [CHANNELS-1:0] toggle_clr_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] toggle_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_press_o
);

  typedef enum logic [1:0] {IDLE, PRESSING, HELD, RELEASING} state_e;

  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  if (PRESS_CYCLES < 2 || RELEASE_CYCLES < 2 ||
      (PRESS_CYCLES >> CNT_W) != 0 || (RELEASE_CYCLES >> CNT_W) != 0) begin : g_bad_cnt
    $error("debounce_multi: qualification counts out of range for CNT_W");
  end
  if (LONG_CYCLES < 1 || (LONG_CYCLES >> LONG_W) != 0) begin : g_bad_long
    $error("debounce_multi: LONG_CYCLES out of range for LONG_W");
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    logic             s1_q, s2_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q, toggle_q, press_q, release_q;
    logic             qual_press;

    assign qual_press = (state_q == PRESSING) && s2_q && (cnt_q == PRESS_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        toggle_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= button_i[g];
        s2_q      <= s1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (toggle_clr_i[g]) toggle_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (s2_q) begin
              state_q <= PRESSING;
              cnt_q   <= CNT_W'(1);
            end
          end
          PRESSING: begin
            if (!s2_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == PRESS_LAST) begin
              state_q  <= HELD;
              cnt_q    <= '0;
              level_q  <= 1'b1;
              press_q  <= 1'b1;
              // A coincident clear loses to the press: the press leaves toggle set.
              toggle_q <= toggle_clr_i[g] ? 1'b1 : ~toggle_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HELD: begin
            if (!s2_q) begin
              state_q <= RELEASING;
              cnt_q   <= CNT_W'(1);
            end
          end
          RELEASING: begin
            if (s2_q) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q == RELEASE_LAST) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end

    assign level_o[g]   = level_q;
    assign toggle_o[g]  = toggle_q;
    assign press_o[g]   = press_q;
    assign release_o[g] = release_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt_q;
    logic              long_q;

    // Saturation at LONG_MAX is what limits the strobe to once per qualified press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        long_cnt_q <= '0;
        long_q     <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (qual_press || state_q == IDLE) begin
          long_cnt_q <= '0;
        end else if (state_q == HELD || state_q == RELEASING) begin
          if (long_cnt_q != LONG_MAX) begin
            long_cnt_q <= long_cnt_q + 1'b1;
            long_q     <= (long_cnt_q == LONG_LAST);
          end
        end
      end
    end

    assign long_press_o[g] = long_q;
`else
    assign long_press_o[g] = 1'b0;
`endif
  end

endmodule
